sccb_master_rw: RTL

Parametrised SCCB master for the OV7670 that supports both register write and register read. A write is 3 phases: ID+W, sub-address, data. A read is a 2-phase write (ID+W, sub-address) followed by a 2-phase read (ID+R, data in, NA bit). It adds a quarter-period clock divider set by parameter, an SDA input sampler and a don't-care-bit status flag. It sits between the camera register-init sequencer and the sclk/sdat tristate pads.

---
 rtl/sccb_master_rw_if.sv | 29 ++
 rtl/sccb_master_rw.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sccb_master_rw_if.sv
// rtl/sccb_master_rw_if.sv - request/response and SDA/SCL pad bundle for the SCCB master
interface sccb_master_rw_if #(
   parameter int c_nb_ov7670_sccb    = 8,
   parameter int c_nb_ov7670_sccb_id = 7
);
   logic                           start_tx;
   logic                           rd_wr;
   logic [c_nb_ov7670_sccb_id-1:0] id;
   logic [c_nb_ov7670_sccb-1:0]    addr;
   logic [c_nb_ov7670_sccb-1:0]    data_wr;
   logic                           ready;
   logic                           finish_tx;
   logic [c_nb_ov7670_sccb-1:0]    data_rd;
   logic                           nack;
   logic                           sclk;
   logic                           sdat_on;
   logic                           sdat_out;
   logic                           sdat_in;

   modport master (
      input  start_tx, rd_wr, id, addr, data_wr, sdat_in,
      output ready, finish_tx, data_rd, nack, sclk, sdat_on, sdat_out
   );

   modport slave (
      output start_tx, rd_wr, id, addr, data_wr, sdat_in,
      input  ready, finish_tx, data_rd, nack, sclk, sdat_on, sdat_out
   );
endinterface

// File: rtl/sccb_master_rw.sv
// rtl/sccb_master_rw.sv - SCCB master with 3-phase write and 2+2-phase read
module sccb_master_rw #(
   parameter int c_sclk_div4_endcnt  = 65,
   parameter int c_nb_cnt_sclk_div4  = 7,
   parameter int c_nb_ov7670_sccb    = 8,
   parameter int c_nb_ov7670_sccb_id = 7
) (
   input  logic             clk,
   input  logic             rst,
   sccb_master_rw_if.master bus
);
   localparam int c_nb_sr  = 3 * c_nb_ov7670_sccb;
   localparam int c_nb_bit = $clog2(c_nb_ov7670_sccb);
   localparam logic [c_nb_cnt_sclk_div4-1:0] c_cnt_last =
      c_nb_cnt_sclk_div4'(c_sclk_div4_endcnt - 1);
   localparam logic [c_nb_cnt_sclk_div4-1:0] c_cnt_one = c_nb_cnt_sclk_div4'(1);
   localparam logic [c_nb_bit-1:0] c_bit_first = c_nb_bit'(c_nb_ov7670_sccb - 1);
   localparam logic [c_nb_bit-1:0] c_bit_one   = c_nb_bit'(1);

   typedef enum logic [2:0] {
      s_idle, s_start, s_send_byte, s_dntc, s_stop, s_bus_free, s_rd_byte, s_na
   } state_t;

   state_t                          state_q, state_d;
   logic [c_nb_cnt_sclk_div4-1:0]   cnt_q, cnt_d;
   logic [1:0]                      q_q, q_d;
   logic [c_nb_bit-1:0]             bit_q, bit_d;
   logic [1:0]                      phase_q, phase_d;
   logic                            pass_q, pass_d;
   logic                            rd_wr_q, rd_wr_d;
   logic [c_nb_sr-1:0]              sr_q, sr_d;
   logic [c_nb_ov7670_sccb-1:0]     rd_sr_q, rd_sr_d;
   logic [c_nb_ov7670_sccb-1:0]     data_rd_q, data_rd_d;
   logic                            nack_q, nack_d;

   logic q_end, bit_end, sample, last_stop, sclk_wave;

   // Quarter-period timing strobes; sample lands mid SCL-high of each bit
   always_comb begin
      q_end     = (cnt_q == c_cnt_last);
      bit_end   = q_end && (q_q == 2'd3);
      sample    = q_end && (q_q == 2'd1);
      last_stop = !rd_wr_q || pass_q;
      sclk_wave = (q_q == 2'd1) || (q_q == 2'd2);
   end

   // Quarter counter and quarter index, parked at zero while idle
   always_comb begin
      cnt_d = cnt_q;
      q_d   = q_q;
      if (state_q == s_idle) begin
         cnt_d = '0;
         q_d   = 2'd0;
      end else if (q_end) begin
         cnt_d = '0;
         q_d   = q_q + 2'd1;
      end else begin
         cnt_d = cnt_q + c_cnt_one;
      end
   end

   // Transaction sequencing, byte shifting and SDA sampling
   always_comb begin
      state_d   = state_q;
      bit_d     = bit_q;
      phase_d   = phase_q;
      pass_d    = pass_q;
      rd_wr_d   = rd_wr_q;
      sr_d      = sr_q;
      rd_sr_d   = rd_sr_q;
      data_rd_d = data_rd_q;
      nack_d    = nack_q;
      case (state_q)
         s_idle: begin
            if (bus.start_tx) begin
               rd_wr_d = bus.rd_wr;
               sr_d    = {bus.id, 1'b0, bus.addr,
                          bus.rd_wr ? {c_nb_ov7670_sccb{1'b1}} : bus.data_wr};
               phase_d = 2'd0;
               pass_d  = 1'b0;
               nack_d  = 1'b0;
               state_d = s_start;
            end
         end
         s_start: begin
            if (bit_end) begin
               bit_d   = c_bit_first;
               state_d = s_send_byte;
            end
         end
         s_send_byte: begin
            if (bit_end) begin
               sr_d = {sr_q[c_nb_sr-2:0], 1'b1};
               if (bit_q == '0) state_d = s_dntc;
               else             bit_d   = bit_q - c_bit_one;
            end
         end
         s_dntc: begin
            if (sample && bus.sdat_in) nack_d = 1'b1;
            if (bit_end) begin
               phase_d = phase_q + 2'd1;
               bit_d   = c_bit_first;
               if (pass_q)
                  state_d = s_rd_byte;
               else if (rd_wr_q ? (phase_q == 2'd1) : (phase_q == 2'd2))
                  state_d = s_stop;
               else
                  state_d = s_send_byte;
            end
         end
         s_rd_byte: begin
            if (sample) rd_sr_d = {rd_sr_q[c_nb_ov7670_sccb-2:0], bus.sdat_in};
            if (bit_end) begin
               if (bit_q == '0) state_d = s_na;
               else             bit_d   = bit_q - c_bit_one;
            end
         end
         s_na: begin
            if (bit_end) state_d = s_stop;
         end
         s_stop: begin
            if (bit_end) begin
               if (last_stop) begin
                  state_d = s_idle;
                  if (rd_wr_q) data_rd_d = rd_sr_q;
               end else begin
                  state_d = s_bus_free;
               end
            end
         end
         s_bus_free: begin
            if (bit_end) begin
               sr_d    = {bus.id, 1'b1, {(2 * c_nb_ov7670_sccb){1'b1}}};
               phase_d = 2'd0;
               pass_d  = 1'b1;
               state_d = s_start;
            end
         end
         default: state_d = s_idle;
      endcase
   end

   // Pad and status decode from state and quarter only, so no mid-quarter glitches
   always_comb begin
      bus.sclk      = 1'b1;
      bus.sdat_on   = 1'b0;
      bus.sdat_out  = 1'b1;
      bus.finish_tx = 1'b0;
      bus.ready     = (state_q == s_idle) && !rst;
      case (state_q)
         s_start: begin
            bus.sdat_on  = 1'b1;
            bus.sclk     = (q_q != 2'd3);
            bus.sdat_out = (q_q == 2'd0);
         end
         s_send_byte: begin
            bus.sdat_on  = 1'b1;
            bus.sclk     = sclk_wave;
            bus.sdat_out = sr_q[c_nb_sr-1];
         end
         s_dntc, s_rd_byte: begin
            bus.sclk = sclk_wave;
         end
         s_na: begin
            bus.sdat_on = 1'b1;
            bus.sclk    = sclk_wave;
         end
         s_stop: begin
            bus.sdat_on   = 1'b1;
            bus.sclk      = (q_q != 2'd0);
            bus.sdat_out  = (q_q >= 2'd2);
            bus.finish_tx = bit_end && last_stop;
         end
         default: ;
      endcase
   end

   assign bus.data_rd = data_rd_q;
   assign bus.nack    = nack_q;

   // State register; asynchronous reset aborts any transfer without a STOP
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= s_idle;
         cnt_q     <= '0;
         q_q       <= 2'd0;
         bit_q     <= '0;
         phase_q   <= 2'd0;
         pass_q    <= 1'b0;
         rd_wr_q   <= 1'b0;
         sr_q      <= '1;
         rd_sr_q   <= '0;
         data_rd_q <= '0;
         nack_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         q_q       <= q_d;
         bit_q     <= bit_d;
         phase_q   <= phase_d;
         pass_q    <= pass_d;
         rd_wr_q   <= rd_wr_d;
         sr_q      <= sr_d;
         rd_sr_q   <= rd_sr_d;
         data_rd_q <= data_rd_d;
         nack_q    <= nack_d;
      end
   end
endmodule
